// File: rtl/fpaddsub_align_shift2_if.sv
// ----------------------------------------------------------------------------
// fpaddsub_align_shift2_if
//   Handshake bundle for the FP add/sub fine-alignment stage.
//   Input side : in_valid / in_ready, Mmin_in, Shift_in, sticky_in, tag_in
//   Output side: out_valid / out_ready, Mmin, G, R, S, tag_out
//   slave  : view taken by the alignment stage itself
//   master : view taken by whatever drives and drains the stage
// ----------------------------------------------------------------------------
interface fpaddsub_align_shift2_if #(
  parameter int MANTISSA = 23,
  parameter int TAG_W    = 9
);
  logic                in_valid;
  logic                in_ready;
  logic [MANTISSA:0]   Mmin_in;
  logic [1:0]          Shift_in;
  logic                sticky_in;
  logic [TAG_W-1:0]    tag_in;

  logic                out_valid;
  logic                out_ready;
  logic [MANTISSA:0]   Mmin;
  logic                G;
  logic                R;
  logic                S;
  logic [TAG_W-1:0]    tag_out;

  modport slave (
    input  in_valid, Mmin_in, Shift_in, sticky_in, tag_in, out_ready,
    output in_ready, out_valid, Mmin, G, R, S, tag_out
  );

  modport master (
    output in_valid, Mmin_in, Shift_in, sticky_in, tag_in, out_ready,
    input  in_ready, out_valid, Mmin, G, R, S, tag_out
  );
endinterface

// File: rtl/fpaddsub_align_shift2.sv
// ----------------------------------------------------------------------------
// fpaddsub_align_shift2
//   Registered fine-alignment stage of the FP add/sub datapath. Applies the
//   remaining 0..3 bit right shift to the coarse-shifted smaller mantissa and
//   produces the aligned mantissa with guard, round and sticky bits. The
//   sideband tag travels with the mantissa as one beat.
//
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous, active-low reset
//     bus  : fpaddsub_align_shift2_if.slave (input and output handshakes)
//
//   Build option:
//     FPADDSUB_ALIGN_SKID_EN defined   -> two-entry skid buffer, registered
//                                          in_ready
//     FPADDSUB_ALIGN_SKID_EN undefined -> single output register,
//                                          combinational in_ready
// ----------------------------------------------------------------------------
module fpaddsub_align_shift2 #(
  parameter int MANTISSA = 23,
  parameter int TAG_W    = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  fpaddsub_align_shift2_if.slave bus
);

  // Beat layout: {Mmin, G, R, S, tag}
  localparam int BEAT_W = MANTISSA + 1 + 3 + TAG_W;

  logic [MANTISSA+3:0] ext;
  logic [BEAT_W-1:0]   in_beat;
  logic [BEAT_W-1:0]   out_beat;
  logic                out_valid;
  logic                in_ready;
  logic                accept;
  logic                consume;

  // Three zero bits appended below the LSB catch what falls off the shift;
  // they become G, R and the local part of S.
  assign ext     = {bus.Mmin_in, 3'b000} >> bus.Shift_in;
  assign in_beat = {ext[MANTISSA+3:3], ext[2], ext[1], ext[0] | bus.sticky_in,
                    bus.tag_in};

  assign accept  = bus.in_valid && in_ready;
  assign consume = out_valid && bus.out_ready;

`ifdef FPADDSUB_ALIGN_SKID_EN
  logic              skid_valid;
  logic [BEAT_W-1:0] skid_beat;
  logic              in_ready_q;
  logic              out_valid_d;
  logic              skid_valid_d;
  logic [BEAT_W-1:0] out_beat_d;
  logic [BEAT_W-1:0] skid_beat_d;

  // The skid entry can only be occupied while the output is occupied, and
  // in_ready is low whenever it is, so accept never coincides with a
  // pending skid beat.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    out_valid_d  = out_valid;
    out_beat_d   = out_beat;
    skid_valid_d = skid_valid;
    skid_beat_d  = skid_beat;
    if (!out_valid || consume) begin
      if (skid_valid) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_beat_d  = in_beat;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: data registers are reset as well because the cleared output
      // values are observable, not just the valid flags.
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      out_valid  <= out_valid_d;
      out_beat   <= out_beat_d;
      skid_valid <= skid_valid_d;
      skid_beat  <= skid_beat_d;
      in_ready_q <= !skid_valid_d;
    end
  end

  assign in_ready = in_ready_q;
`else
  // A consumed beat frees the register in the same edge, so a new beat can
  // replace it without a bubble.
  assign in_ready = !out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_beat  <= in_beat;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign {bus.Mmin, bus.G, bus.R, bus.S, bus.tag_out} = out_beat;

endmodule

// File: tb/tb_fpaddsub_align_shift2.sv
// ----------------------------------------------------------------------------
// tb_fpaddsub_align_shift2
//   Self-checking bench for fpaddsub_align_shift2. Accepted beats are pushed
//   into a scoreboard queue as expected results from an independent model;
//   consumed beats are popped and compared. Honors FPADDSUB_ALIGN_SKID_EN.
// ----------------------------------------------------------------------------
module tb_fpaddsub_align_shift2;
  localparam int MANTISSA = 23;
  localparam int TAG_W    = 9;
  localparam int MW       = MANTISSA + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpaddsub_align_shift2_if #(.MANTISSA(MANTISSA), .TAG_W(TAG_W)) bus ();

  fpaddsub_align_shift2 #(.MANTISSA(MANTISSA), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [MW-1:0]    mmin;
    logic             g;
    logic             r;
    logic             s;
    logic [TAG_W-1:0] tag;
  } beat_t;

  typedef struct packed {
    logic [MW-1:0]    m;
    logic [1:0]       sh;
    logic             st;
    logic [TAG_W-1:0] tag;
  } stim_t;

  typedef struct {
    bit    consumed;
    bit    accepted;
    bit    underflow;
    logic  in_ready;
    logic  out_valid;
    int    held;
    beat_t got;
    beat_t exp;
  } obs_t;

  beat_t sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  // Reference: bits shifted out land in G, R, then S in that order.
  function automatic beat_t model(input stim_t st);
    beat_t b;
    b.mmin = st.m >> st.sh;
    b.tag  = st.tag;
    b.g    = 1'b0;
    b.r    = 1'b0;
    b.s    = st.st;
    case (st.sh)
      2'd1: b.g = st.m[0];
      2'd2: begin b.g = st.m[1]; b.r = st.m[0]; end
      2'd3: begin b.g = st.m[2]; b.r = st.m[1]; b.s = st.st | st.m[0]; end
      default: ;
    endcase
    return b;
  endfunction

  // One clock cycle: drive inputs after the falling edge, observe settled
  // outputs, and update the scoreboard for the handshakes that will fire on
  // the coming rising edge.
  task automatic cycle(input bit iv, input stim_t st, input bit ordy, output obs_t o);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.Mmin_in   = st.m;
    bus.Shift_in  = st.sh;
    bus.sticky_in = st.st;
    bus.tag_in    = st.tag;
    bus.out_ready = ordy;
    #1;
    o.held      = sb.size();
    o.in_ready  = bus.in_ready;
    o.out_valid = bus.out_valid;
    o.got       = {bus.Mmin, bus.G, bus.R, bus.S, bus.tag_out};
    o.consumed  = (bus.out_valid === 1'b1) && ordy;
    o.accepted  = iv && (bus.in_ready === 1'b1);
    o.underflow = 1'b0;
    o.exp       = '0;
    if (o.consumed) begin
      if (sb.size() > 0) o.exp = sb.pop_front();
      else o.underflow = 1'b1;
    end
    if (o.accepted) sb.push_back(model(st));
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.m   = MW'($urandom());
    s.sh  = 2'($urandom_range(0, 3));
    s.st  = 1'($urandom_range(0, 1));
    s.tag = TAG_W'($urandom());
    return s;
  endfunction

  task automatic test_reset();
    #1;
    n_assert++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        {bus.Mmin, bus.G, bus.R, bus.S, bus.tag_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: out_valid=%b in_ready=%b Mmin=%h GRS=%b%b%b tag=%h, required 0/1/0/000/0",
               bus.out_valid, bus.in_ready, bus.Mmin, bus.G, bus.R, bus.S, bus.tag_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_midstream();
    obs_t  o;
    stim_t s;
    s = '{m: 24'h123456, sh: 2'd2, st: 1'b1, tag: 9'h0F3};
    cycle(1'b1, s, 1'b0, o);
    s.m = 24'h654321;
    cycle(1'b1, s, 1'b0, o);
    cycle(1'b0, '0, 1'b0, o);
    n_assert++;
    if (o.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: out_valid=%b required 1", o.out_valid);
    end
    bus.in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_assert++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        {bus.Mmin, bus.G, bus.R, bus.S, bus.tag_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b Mmin=%h GRS=%b%b%b tag=%h, required 0/1/0/000/0",
               bus.out_valid, bus.in_ready, bus.Mmin, bus.G, bus.R, bus.S, bus.tag_out);
    end
    sb.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed(input string name, input stim_t st, input beat_t lit);
    obs_t o;
    cycle(1'b1, st, 1'b1, o);
    n_assert++;
    if (!o.accepted) begin
      n_fail++;
      $display("FAIL %s_accept: in_ready=%b required 1", name, o.in_ready);
    end
    cycle(1'b0, '0, 1'b1, o);
    n_assert++;
    if (o.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid=%b required 1", name, o.out_valid);
    end
    n_assert++;
    if (!o.consumed || o.underflow || o.got !== o.exp) begin
      n_fail++;
      $display("FAIL %s_model: got %h required %h", name, o.got, o.exp);
    end
    n_assert++;
    if (o.got !== lit) begin
      n_fail++;
      $display("FAIL %s_value: got Mmin=%h GRS=%b%b%b tag=%h required Mmin=%h GRS=%b%b%b tag=%h",
               name, o.got.mmin, o.got.g, o.got.r, o.got.s, o.got.tag,
               lit.mmin, lit.g, lit.r, lit.s, lit.tag);
    end
    sb.delete();
  endtask

  task automatic test_fine_shift3();
    test_directed("shift3", '{m: 24'h800001, sh: 2'd3, st: 1'b0, tag: 9'h011},
                  '{mmin: 24'h100000, g: 1'b0, r: 1'b0, s: 1'b1, tag: 9'h011});
  endtask

  task automatic test_fine_shift1_sticky();
    test_directed("shift1_sticky", '{m: 24'hFFFFFF, sh: 2'd1, st: 1'b1, tag: 9'h0C2},
                  '{mmin: 24'h7FFFFF, g: 1'b1, r: 1'b0, s: 1'b1, tag: 9'h0C2});
  endtask

  task automatic test_zero_shift();
    test_directed("zero_shift", '{m: 24'hABCDEF, sh: 2'd0, st: 1'b0, tag: 9'h1A5},
                  '{mmin: 24'hABCDEF, g: 1'b0, r: 1'b0, s: 1'b0, tag: 9'h1A5});
  endtask

  task automatic test_backpressure();
    obs_t o;
    obs_t prev;
    bit   prev_stall = 1'b0;
    bit   ordy;
    bit   exp_rdy;
    int   sent = 0;
    int   recv = 0;
    for (int c = 1; c <= 40 && recv < 4; c++) begin
      ordy = !(c >= 2 && c <= 4);
      cycle(sent < 4, rand_stim(), ordy, o);
      if (o.accepted) sent++;
`ifdef FPADDSUB_ALIGN_SKID_EN
      exp_rdy = (o.held < 2);
`else
      exp_rdy = (o.held == 0) || ordy;
`endif
      n_assert++;
      if (o.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_in_ready cycle %0d: in_ready=%b required %b", c, o.in_ready, exp_rdy);
      end
      if (prev_stall) begin
        n_assert++;
        if (o.out_valid !== 1'b1 || o.got !== prev.got) begin
          n_fail++;
          $display("FAIL bp_hold cycle %0d: out_valid=%b data=%h required 1 / %h",
                   c, o.out_valid, o.got, prev.got);
        end
      end
      if (o.consumed) begin
        recv++;
        n_assert++;
        if (o.underflow || o.got !== o.exp) begin
          n_fail++;
          $display("FAIL bp_data beat %0d: got %h required %h", recv, o.got, o.exp);
        end
      end
      prev_stall = (o.out_valid === 1'b1) && !ordy;
      prev       = o;
    end
    n_assert++;
    if (recv != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: delivered %0d beats (pending %0d) required 4 (0)", recv, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int   recv = 0;
    for (int c = 0; c < 101; c++) begin
      cycle(c < 100, rand_stim(), 1'b1, o);
      if (c < 100) begin
        n_assert++;
        if (!o.accepted) begin
          n_fail++;
          $display("FAIL b2b_accept cycle %0d: in_ready=%b required 1", c, o.in_ready);
        end
      end
      if (c > 0) begin
        n_assert++;
        if (!o.consumed || o.underflow || o.got !== o.exp) begin
          n_fail++;
          $display("FAIL b2b_data cycle %0d: valid=%b got %h required %h", c, o.out_valid, o.got, o.exp);
        end
        if (o.consumed) recv++;
      end
    end
    cycle(1'b0, '0, 1'b1, o);
    n_assert++;
    if (recv != 100 || o.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: delivered %0d, trailing out_valid=%b required 100, 0", recv, o.out_valid);
    end
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.Mmin_in   = '0;
    bus.Shift_in  = '0;
    bus.sticky_in = 1'b0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fine_shift3();
    test_fine_shift1_sticky();
    test_zero_shift();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_fine_shift3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fpaddsub_align_shift2.md
# fpaddsub_align_shift2

Registered fine-alignment stage of the FP add/sub datapath, directly downstream of the coarse 16|12|8|4 alignment shifter. It takes the coarse-shifted smaller mantissa, applies the remaining 0–3 bit right shift, and produces the aligned mantissa plus guard, round and sticky bits. Output is registered behind a valid/ready handshake so the adder stage can stall without losing operands.

## Interface
- `TAG_W`, default 9: width of the sideband tag (sign, exponent, operation) carried alongside the mantissa unchanged.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: an input beat is presented.
- `in_ready` out 1: the stage can accept a beat this cycle.
- `Mmin_in` in `MANTISSA+1`: coarse-shifted smaller mantissa, hidden bit included.
- `Shift_in` in 2: fine shift amount, exponent-difference bits [1:0].
- `sticky_in` in 1: OR of bits already discarded upstream.
- `tag_in` in `TAG_W`: sideband tag.
- `out_valid` out 1: an output beat is presented.
- `out_ready` in 1: downstream accepts the beat.
- `Mmin` out `MANTISSA+1`: fully aligned smaller mantissa.
- `G`, `R`, `S` out 1 each: guard, round and sticky bits.
- `tag_out` out `TAG_W`: tag of the presented beat.

## Operation
- Arithmetic, computed combinationally on the input side:
  - ext = {Mmin_in, 3'b000} >> Shift_in, which is `MANTISSA+4` bits wide.
  - Mmin = ext[`MANTISSA+3`:3].
  - G = ext[2], R = ext[1].
  - S = ext[0] | sticky_in.
- Shift_in = 0 passes Mmin_in through, with G = R = 0 and S = sticky_in.
- No rounding and no normalisation in this stage.
- A beat is accepted when in_valid && in_ready. It is consumed when out_valid && out_ready.
- Data and tag move as one atomic beat. Beats are never reordered, duplicated or dropped.
- While out_valid && !out_ready, the output registers hold `Mmin`/`G`/`R`/`S`/`tag_out` stable.
- An input beat with in_ready low is ignored; the upstream stage holds it.
- Simultaneous consume and accept with the output register occupied: the new beat replaces the consumed one in the same edge, and out_valid stays 1.

## Timing
- Latency: 1 cycle. A beat accepted at edge N is presented from edge N onward (out_valid high in cycle N+1).
- Throughput: 1 beat/cycle with out_ready held high.
- Reset (rst low, asynchronous):
  - out_valid = 0, Mmin = 0, G = R = S = 0, tag_out = 0.
  - in_ready = 1.
  - The skid entry is emptied.
- Reset mid-operation discards all held beats immediately, without waiting for a clock edge.
- First accept is possible on the first edge after rst deasserts.

## Configuration
- `FPADDSUB_ALIGN_SKID_EN` defined:
  - Two-entry skid buffer: output register plus one skid register.
  - in_ready is a register output, so there is no combinational path from out_ready to in_ready.
  - in_ready = !skid_valid.
  - A beat accepted while the output is stalled goes to the skid register. The skid register moves to the output on the next consume.
  - At most one stall bubble is absorbed.
- `FPADDSUB_ALIGN_SKID_EN` undefined:
  - Single output register.
  - in_ready = !out_valid || out_ready, which is combinational.
  - Same latency and data results.

## Test plan
- Reset values: assert rst low mid-stream with out_valid=1 -> out_valid=0, `Mmin`=0, G/R/S=0, in_ready=1 immediately.
- Fine shift 3: Mmin_in=24'h800001, Shift_in=3, sticky_in=0 -> `Mmin`=24'h100000, G=0, R=0, S=1 one cycle later.
- Fine shift 1 with upstream sticky: Mmin_in=24'hFFFFFF, Shift_in=1, sticky_in=1 -> `Mmin`=24'h7FFFFF, G=1, R=0, S=1.
- Zero shift passthrough: Mmin_in=24'hABCDEF, Shift_in=0, sticky_in=0, tag_in=9'h1A5 -> `Mmin`=24'hABCDEF, G=R=S=0, tag_out=9'h1A5.
- Backpressure: stream 4 beats with out_ready low for cycles 2–4 -> outputs held stable while stalled, all 4 beats delivered in order.
  - With SKID_EN: in_ready drops only after the skid register fills.
- Full throughput: 100 random beats with in_valid and out_ready held high -> one beat per cycle, every result matching the ext reference model.
